// File: rtl/memory_arbiter.sv
// Two-requester RAM arbiter: data side has priority, instruction fetch shares the single RAM port.
// Optional starvation guard (ARB_STARVE_GUARD_EN) forces a fetch grant after STARVE_LIMIT data wins.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_e;

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;
  localparam logic [2:0] LIMIT3    = 3'(STARVE_LIMIT);

  state_e      state_q;
  logic        ren_q, wen_q, err_q;
  logic [31:0] addr_q, store_q;

  logic dreq, ihit, dhit, gnt_req, force_i;

  assign dreq    = dREN | dWEN;
  assign ihit    = (state_q == IGNT) && (ramstate == RS_ACCESS) && iREN;
  assign dhit    = (state_q == DGNT) && (ramstate == RS_ACCESS) && dreq;
  assign gnt_req = (state_q == IGNT) ? iREN : dreq;

  assign iwait = iREN & ~ihit;
  assign dwait = dreq & ~dhit;
  assign iload = ihit ? ramload : 32'h0;
  assign dload = dhit ? ramload : 32'h0;

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign err      = err_q;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] cnt_q;

  assign force_i = iREN && (cnt_q == LIMIT3);

  // Counts data wins that happened while a fetch was waiting; saturates at the limit.
  always_ff @(posedge CLK) begin
    if (RST)                            cnt_q <= 3'd0;
    else if (!iREN || ihit)             cnt_q <= 3'd0;
    else if (dhit && cnt_q != LIMIT3)   cnt_q <= cnt_q + 3'd1;
  end
`else
  logic unused_limit;

  assign force_i      = 1'b0;
  assign unused_limit = ^LIMIT3;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= 32'h0;
      store_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (force_i || (iREN && !dreq)) begin
            state_q <= IGNT;
            ren_q   <= 1'b1;
            wen_q   <= 1'b0;
            addr_q  <= iaddr;
            store_q <= 32'h0;
          end else if (dreq) begin
            // Write wins when both data strobes are up.
            state_q <= DGNT;
            ren_q   <= ~dWEN;
            wen_q   <= dWEN;
            addr_q  <= daddr;
            store_q <= dstore;
          end
        end
        IGNT, DGNT: begin
          if (ramstate == RS_ERROR) err_q <= 1'b1;
          if (ramstate == RS_ERROR || ramstate == RS_ACCESS || !gnt_req) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter; hits are checked by a monitor against queued expectations.
module tb_memory_arbiter;

  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = 32'h0, daddr = 32'h0, dstore = 32'h0, ramload = 32'h0;
  logic [1:0]  ramstate = FREE;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err;

  int n_chk = 0, n_fail = 0;
  logic [31:0] iq[$], dq[$];

  memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Monitor: any observed hit must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!RST) begin
      if (iREN && !iwait) begin
        if (iq.size() == 0) check("ihit_unexpected", 32'h1, 32'h0);
        else check("iload", iload, iq.pop_front());
      end else check("iload_zero", iload, 32'h0);
      if ((dREN || dWEN) && !dwait) begin
        if (dq.size() == 0) check("dhit_unexpected", 32'h1, 32'h0);
        else check("dload", dload, dq.pop_front());
      end else check("dload_zero", dload, 32'h0);
    end
  end

  initial begin
    int nd, nd_at_i;
    logic ig;

    // Reset state
    tick(); tick(); smp();
    check("rst_ramREN", {31'h0, ramREN}, 32'h0);
    check("rst_ramWEN", {31'h0, ramWEN}, 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_iload", iload, 32'h0);
    check("rst_dload", dload, 32'h0);
    check("rst_iwait", {31'h0, iwait}, 32'h0);
    tick(); RST = 1'b0;

    // Single fetch, RAM answers on the first grant cycle
    tick(); iREN = 1'b1; iaddr = 32'h40; smp();
    check("f_idle_ramREN", {31'h0, ramREN}, 32'h0);
    check("f_idle_iwait", {31'h0, iwait}, 32'h1);
    tick(); ramstate = ACCESS; ramload = 32'h8C220004; iq.push_back(32'h8C220004); smp();
    check("f_ramREN", {31'h0, ramREN}, 32'h1);
    check("f_ramaddr", ramaddr, 32'h40);
    check("f_iwait", {31'h0, iwait}, 32'h0);
    tick(); iREN = 1'b0; ramstate = FREE; smp();
    check("f_after_ramREN", {31'h0, ramREN}, 32'h0);

    // Contention: data first, then fetch in the following idle cycle
    tick(); iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; smp();
    check("c_idle_ramREN", {31'h0, ramREN}, 32'h0);
    tick(); ramstate = ACCESS; ramload = 32'h11111111; dq.push_back(32'h11111111); smp();
    check("c_d_ramaddr", ramaddr, 32'h100);
    check("c_d_ramREN", {31'h0, ramREN}, 32'h1);
    check("c_d_iwait", {31'h0, iwait}, 32'h1);
    tick(); dREN = 1'b0; ramstate = FREE; smp();
    check("c_gap_ramREN", {31'h0, ramREN}, 32'h0);
    check("c_gap_iwait", {31'h0, iwait}, 32'h1);
    tick(); ramstate = ACCESS; ramload = 32'h22222222; iq.push_back(32'h22222222); smp();
    check("c_i_ramaddr", ramaddr, 32'h44);
    tick(); iREN = 1'b0; ramstate = FREE;

    // Write priority with three wait states; inputs change mid-grant
    tick(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; smp();
    check("w_idle_dwait", {31'h0, dwait}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick(); ramstate = BUSY; daddr = 32'h999; dstore = 32'h12345678; smp();
      check("w_busy_ramWEN", {31'h0, ramWEN}, 32'h1);
      check("w_busy_ramREN", {31'h0, ramREN}, 32'h0);
      check("w_busy_ramstore", ramstore, 32'hDEADBEEF);
      check("w_busy_ramaddr", ramaddr, 32'h200);
      check("w_busy_dwait", {31'h0, dwait}, 32'h1);
    end
    tick(); ramstate = ACCESS; ramload = 32'hABCD0000; dq.push_back(32'hABCD0000); smp();
    check("w_acc_ramWEN", {31'h0, ramWEN}, 32'h1);
    check("w_acc_ramstore", ramstore, 32'hDEADBEEF);
    tick(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; smp();
    check("w_after_ramWEN", {31'h0, ramWEN}, 32'h0);

    // Abort: fetch withdrawn while the RAM is busy
    tick(); iREN = 1'b1; iaddr = 32'h80; smp();
    tick(); ramstate = BUSY; smp();
    check("a_ramREN", {31'h0, ramREN}, 32'h1);
    check("a_iwait", {31'h0, iwait}, 32'h1);
    tick(); iREN = 1'b0; smp();
    check("a_drop_ramREN", {31'h0, ramREN}, 32'h1);
    tick(); ramstate = FREE; smp();
    check("a_idle_ramREN", {31'h0, ramREN}, 32'h0);
    check("a_iload", iload, 32'h0);

    // RAM error during a data grant
    tick(); dREN = 1'b1; daddr = 32'h300; smp();
    check("e_pre_err", {31'h0, err}, 32'h0);
    tick(); ramstate = ERROR; ramload = 32'h55555555; smp();
    check("e_dwait", {31'h0, dwait}, 32'h1);
    check("e_dload", dload, 32'h0);
    tick(); dREN = 1'b0; ramstate = FREE; smp();
    check("e_err", {31'h0, err}, 32'h1);
    check("e_ramREN", {31'h0, ramREN}, 32'h0);
    tick(); tick(); smp();
    check("e_err_sticky", {31'h0, err}, 32'h1);

    // Reset in the middle of a busy data grant
    tick(); dREN = 1'b1; daddr = 32'h400; smp();
    tick(); ramstate = BUSY; smp();
    check("r_ramREN_pre", {31'h0, ramREN}, 32'h1);
    RST = 1'b1;
    tick(); smp();
    check("r_ramREN", {31'h0, ramREN}, 32'h0);
    check("r_err", {31'h0, err}, 32'h0);
    check("r_ramaddr", ramaddr, 32'h0);
    check("r_dwait", {31'h0, dwait}, 32'h1);
    check("r_dload", dload, 32'h0);
    tick(); RST = 1'b0; dREN = 1'b0; ramstate = FREE;
    tick();

    // Starvation: fetch held against continuous data reads
    iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h600;
    nd = 0; nd_at_i = -1; ig = 1'b0;
    for (int c = 0; c < 20 && !ig; c++) begin
      tick();
      if (ramREN) begin
        ramstate = ACCESS;
        if (ramaddr == 32'h500) begin
          ramload = 32'hC0DE0500; iq.push_back(32'hC0DE0500); ig = 1'b1; nd_at_i = nd;
        end else begin
          ramload = 32'hDA7A0000 + 32'(c); dq.push_back(32'hDA7A0000 + 32'(c)); nd++;
        end
      end else ramstate = FREE;
      smp();
    end
`ifdef ARB_STARVE_GUARD_EN
    check("g_igrant", {31'h0, ig}, 32'h1);
    check("g_data_before_i", 32'(nd_at_i), 32'd4);
`else
    check("g_no_igrant", {31'h0, ig}, 32'h0);
    check("g_data_count", 32'(nd), 32'd10);
`endif
    tick(); iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    tick(); tick(); smp();
    check("q_i_empty", 32'(iq.size()), 32'd0);
    check("q_d_empty", 32'(dq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
